alu_result_stage: RTL and testbench

- Registered output stage directly downstream of the 16-bit arithmetic unit.
- Captures result C, vout, cout and the operation code into a 2-entry skid buffer with valid/ready handshakes on both sides.
- Derives a masked flag nibble {N,Z,V,C} and maintains a sticky overflow status for the register-file/writeback stage that consumes it.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_result_stage_if.sv | 29 ++
 rtl/alu_flag_gen.sv | 24 ++
 rtl/alu_result_stage.sv | 131 +++++++++++++
 tb/tb_alu_result_stage.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result path: op codes, flag bit positions
// and the per-code masks that decide which flags an operation may raise.
package alu_pkg;

  localparam int unsigned CODE_W = 3;
  localparam int unsigned FLAG_W = 4;
  localparam int unsigned STAT_W = 16;

  localparam logic [CODE_W-1:0] OP_SADD = 3'b000;
  localparam logic [CODE_W-1:0] OP_UADD = 3'b001;
  localparam logic [CODE_W-1:0] OP_SSUB = 3'b010;
  localparam logic [CODE_W-1:0] OP_USUB = 3'b011;
  localparam logic [CODE_W-1:0] OP_SINC = 3'b100;
  localparam logic [CODE_W-1:0] OP_SDEC = 3'b101;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_C = 0;

  // Signed ops report overflow, unsigned ops report carry/borrow.
  localparam logic [7:0] V_VALID_MASK = (8'(1) << OP_SADD) | (8'(1) << OP_SSUB) |
                                        (8'(1) << OP_SINC) | (8'(1) << OP_SDEC);
  localparam logic [7:0] C_VALID_MASK = (8'(1) << OP_UADD) | (8'(1) << OP_USUB);

  typedef struct packed {
    logic [FLAG_W-1:0] flags;
    logic              err;
  } entry_meta_t;

  function automatic logic code_in_mask(input logic [7:0] mask, input logic [CODE_W-1:0] code);
    return mask[code];
  endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// Upstream/downstream valid-ready bus of the ALU result stage.
interface alu_result_stage_if #(
  parameter int unsigned WIDTH = 16
);
  import alu_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_c;
  logic              in_vout;
  logic              in_cout;
  logic [CODE_W-1:0] in_code;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic [FLAG_W-1:0] out_flags;
  logic              out_err;

  modport master (
    output in_valid, in_c, in_vout, in_cout, in_code, out_ready,
    input  in_ready, out_valid, out_data, out_flags, out_err
  );

  modport slave (
    input  in_valid, in_c, in_vout, in_cout, in_code, out_ready,
    output in_ready, out_valid, out_data, out_flags, out_err
  );

endinterface

// File: rtl/alu_flag_gen.sv
// Combinational {N,Z,V,C} and illegal-code derivation for one ALU result.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0]  in_c,
  input  logic              in_vout,
  input  logic              in_cout,
  input  logic [CODE_W-1:0] in_code,
  output entry_meta_t       meta_c
);

  // AND with the mask bit so an X on a masked-off vout/cout resolves to 0.
  always_comb begin
    meta_c         = '0;
    meta_c.flags[FLAG_N] = in_c[WIDTH-1];
    meta_c.flags[FLAG_Z] = (in_c == '0);
    meta_c.flags[FLAG_V] = code_in_mask(V_VALID_MASK, in_code) & in_vout;
    meta_c.flags[FLAG_C] = code_in_mask(C_VALID_MASK, in_code) & in_cout;
    meta_c.err           = in_code[2] & in_code[1];
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered 2-entry skid buffer behind the 16-bit ALU with flag derivation
// and sticky overflow. Optional pop counter enabled by RESULT_STAT_COUNT_EN.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_result_stage_if.slave  bus,
  input  logic               clr_sticky,
  output logic               ovf_sticky
`ifdef RESULT_STAT_COUNT_EN
  ,
  output logic [STAT_W-1:0]  op_count
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  entry_meta_t      new_meta_c;
  logic [WIDTH-1:0] head_data, head_data_n;
  entry_meta_t      head_meta, head_meta_n;
  logic             head_valid, head_valid_n;
  logic [WIDTH-1:0] skid_data, skid_data_n;
  entry_meta_t      skid_meta, skid_meta_n;
  logic             skid_valid, skid_valid_n;
  logic             in_ready_q, in_ready_n;
  logic             sticky_n;
  logic             push_c, pop_c;
  logic [CNT_W-1:0] count_n;

  alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .in_c    (bus.in_c),
    .in_vout (bus.in_vout),
    .in_cout (bus.in_cout),
    .in_code (bus.in_code),
    .meta_c  (new_meta_c)
  );

  assign push_c = bus.in_valid & in_ready_q;
  assign pop_c  = head_valid & bus.out_ready;

  // Head register feeds out_* directly; skid register holds the second entry.
  always_comb begin
    head_data_n  = head_data;
    head_meta_n  = head_meta;
    head_valid_n = head_valid;
    skid_data_n  = skid_data;
    skid_meta_n  = skid_meta;
    skid_valid_n = skid_valid;

    if (!head_valid) begin
      if (push_c) begin
        head_data_n  = bus.in_c;
        head_meta_n  = new_meta_c;
        head_valid_n = 1'b1;
      end
    end else if (skid_valid) begin
      if (pop_c) begin
        head_data_n  = skid_data;
        head_meta_n  = skid_meta;
        skid_valid_n = 1'b0;
      end
    end else begin
      if (push_c && pop_c) begin
        head_data_n  = bus.in_c;
        head_meta_n  = new_meta_c;
      end else if (push_c) begin
        skid_data_n  = bus.in_c;
        skid_meta_n  = new_meta_c;
        skid_valid_n = 1'b1;
      end else if (pop_c) begin
        head_valid_n = 1'b0;
      end
    end

    count_n    = CNT_W'(head_valid_n) + CNT_W'(skid_valid_n);
    in_ready_n = (count_n != CNT_W'(DEPTH));
  end

  // A set from an accepted V=1 entry takes priority over a clear.
  always_comb begin
    sticky_n = ovf_sticky;
    if (clr_sticky)                          sticky_n = 1'b0;
    if (push_c && new_meta_c.flags[FLAG_V])  sticky_n = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_data  <= '0;
      head_meta  <= '0;
      head_valid <= 1'b0;
      skid_data  <= '0;
      skid_meta  <= '0;
      skid_valid <= 1'b0;
      in_ready_q <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      head_data  <= head_data_n;
      head_meta  <= head_meta_n;
      head_valid <= head_valid_n;
      skid_data  <= skid_data_n;
      skid_meta  <= skid_meta_n;
      skid_valid <= skid_valid_n;
      in_ready_q <= in_ready_n;
      ovf_sticky <= sticky_n;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = head_valid;
  assign bus.out_data  = head_data;
  assign bus.out_flags = head_meta.flags;
  assign bus.out_err   = head_meta.err;

`ifdef RESULT_STAT_COUNT_EN
  // Saturating pop counter; a clear coinciding with a pop restarts at 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (clr_sticky) begin
      op_count <= STAT_W'(pop_c);
    end else if (pop_c && (op_count != '1)) begin
      op_count <= op_count + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage.
module tb_alu_result_stage;
  import alu_pkg::*;

  localparam int unsigned WIDTH = 16;

  logic clk;
  logic rst_n;
  logic clr_sticky;
  logic ovf_sticky;
`ifdef RESULT_STAT_COUNT_EN
  logic [STAT_W-1:0] op_count;
`endif

  int n_checks;
  int n_errors;

  alu_result_stage_if #(.WIDTH(WIDTH)) bus ();

  alu_result_stage #(.WIDTH(WIDTH), .DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .clr_sticky (clr_sticky),
    .ovf_sticky (ovf_sticky)
`ifdef RESULT_STAT_COUNT_EN
    ,
    .op_count   (op_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] c, input logic [2:0] code,
                       input logic vo, input logic co);
    bus.in_valid = v;
    bus.in_c     = c;
    bus.in_code  = code;
    bus.in_vout  = vo;
    bus.in_cout  = co;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    clr_sticky = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 16'h0000, 3'b000, 1'b0, 1'b0);
    tick();
    tick();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'h0);
    check("rst_out_flags", 32'(bus.out_flags), 32'h0);
    check("rst_out_err",   32'(bus.out_err),   32'd0);
    check("rst_sticky",    32'(ovf_sticky),    32'd0);
    rst_n = 1'b1;
    tick();
    check("rel_in_ready", 32'(bus.in_ready), 32'd1);

    // Zero result with unsigned carry.
    bus.out_ready = 1'b1;
    drive(1'b1, 16'h0000, OP_UADD, 1'b0, 1'b1);
    tick();
    drive(1'b0, 16'h0000, 3'b000, 1'b0, 1'b0);
    check("t1_valid", 32'(bus.out_valid), 32'd1);
    check("t1_data",  32'(bus.out_data),  32'h0000);
    check("t1_flags", 32'(bus.out_flags), 32'b0101);
    check("t1_err",   32'(bus.out_err),   32'd0);
    tick();
    check("t1_empty", 32'(bus.out_valid), 32'd0);

    // Signed overflow sets sticky; set beats simultaneous clear.
    drive(1'b1, 16'h8000, OP_SADD, 1'b1, 1'b0);
    tick();
    drive(1'b0, 16'h0000, 3'b000, 1'b0, 1'b0);
    check("t2_flags",  32'(bus.out_flags), 32'b1010);
    check("t2_sticky", 32'(ovf_sticky),    32'd1);
    tick();
    drive(1'b1, 16'h0001, OP_SINC, 1'b1, 1'b0);
    clr_sticky = 1'b1;
    tick();
    drive(1'b0, 16'h0000, 3'b000, 1'b0, 1'b0);
    clr_sticky = 1'b0;
    check("t2_set_wins", 32'(ovf_sticky),    32'd1);
    check("t2_flags2",   32'(bus.out_flags), 32'b0010);
    tick();
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    check("t2_cleared", 32'(ovf_sticky), 32'd0);

    // Illegal code: data forwarded, only N/Z survive, sticky untouched.
    drive(1'b1, 16'hFFFF, 3'b110, 1'b1, 1'b1);
    tick();
    drive(1'b0, 16'h0000, 3'b000, 1'b0, 1'b0);
    check("t5_err",    32'(bus.out_err),   32'd1);
    check("t5_data",   32'(bus.out_data),  32'hFFFF);
    check("t5_flags",  32'(bus.out_flags), 32'b1000);
    check("t5_sticky", 32'(ovf_sticky),    32'd0);
    tick();

    // Back-pressure: third push held until space frees, order preserved.
    bus.out_ready = 1'b0;
    drive(1'b1, 16'h0001, OP_UADD, 1'b0, 1'b0);
    tick();
    check("t3_rdy1", 32'(bus.in_ready), 32'd1);
    drive(1'b1, 16'h0002, OP_UADD, 1'b0, 1'b0);
    tick();
    check("t3_rdy2",  32'(bus.in_ready), 32'd0);
    check("t3_head1", 32'(bus.out_data), 32'h0001);
    drive(1'b1, 16'h0003, OP_UADD, 1'b0, 1'b0);
    tick();
    check("t3_full_rdy", 32'(bus.in_ready), 32'd0);
    check("t3_hold",     32'(bus.out_data), 32'h0001);
    bus.out_ready = 1'b1;
    tick();
    check("t3_head2",  32'(bus.out_data), 32'h0002);
    check("t3_rdy3",   32'(bus.in_ready), 32'd1);
    tick();
    drive(1'b0, 16'h0000, 3'b000, 1'b0, 1'b0);
    check("t3_head3",  32'(bus.out_data),  32'h0003);
    check("t3_valid3", 32'(bus.out_valid), 32'd1);
    tick();
    check("t3_empty", 32'(bus.out_valid), 32'd0);

    // Streaming at count=1 with push and pop every cycle.
    drive(1'b1, 16'h0100, OP_SSUB, 1'b0, 1'b0);
    tick();
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 16'(16'h0100 + i), OP_SSUB, 1'b0, 1'b0);
      tick();
      check("t4_data",  32'(bus.out_data),  32'(16'h0100 + i));
      check("t4_valid", 32'(bus.out_valid), 32'd1);
      check("t4_ready", 32'(bus.in_ready),  32'd1);
    end
    drive(1'b0, 16'h0000, 3'b000, 1'b0, 1'b0);
    tick();
    check("t4_empty", 32'(bus.out_valid), 32'd0);
`ifdef RESULT_STAT_COUNT_EN
    check("op_count", 32'(op_count), 32'd15);
`endif

    // Reset with a full buffer discards everything.
    bus.out_ready = 1'b0;
    drive(1'b1, 16'hAAAA, OP_SADD, 1'b1, 1'b0);
    tick();
    drive(1'b1, 16'h5555, OP_SADD, 1'b0, 1'b0);
    tick();
    drive(1'b0, 16'h0000, 3'b000, 1'b0, 1'b0);
    check("t6_full",   32'(bus.in_ready), 32'd0);
    check("t6_sticky", 32'(ovf_sticky),   32'd1);
    rst_n = 1'b0;
    tick();
    check("t6_rst_valid",  32'(bus.out_valid), 32'd0);
    check("t6_rst_sticky", 32'(ovf_sticky),    32'd0);
    check("t6_rst_ready",  32'(bus.in_ready),  32'd0);
    check("t6_rst_data",   32'(bus.out_data),  32'h0);
    rst_n = 1'b1;
    tick();
    check("t6_rel_ready", 32'(bus.in_ready),  32'd1);
    check("t6_rel_valid", 32'(bus.out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
